uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 8-bit UART transmitter between NUM_REQ
//  byte sources (e.g. NN result dump, status/debug reporter). Selects a requester,
//  latches its byte and pulses the transmitter's enable once. It then waits for the
//  transmitter's done pulse before granting again. A watchdog and a post-reset
//  holdoff keep the shared transmitter from hanging the arbiter or dropping bytes.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8)
//  ID_W         2     width of grant_id, >= clog2(NUM_REQ)
//  HOLDOFF_CYC  64    cycles spent in HOLDOFF after reset (>= one full UART frame)
//  TIMEOUT_CYC  1024  max cycles in WAIT_DONE before abort (>= one full UART frame)
// PORTS
//  clk        in   1            system clock, all logic on rising edge
//  rst_n      in   1            synchronous reset, active low
//  req        in   NUM_REQ      req[i]=1: requester i has a valid byte, held until ack[i]
//  data_in    in   8*NUM_REQ    byte of requester i at data_in[8*i+7:8*i]
//  ack        out  NUM_REQ      one-cycle pulse: requester i's byte taken, may drop/change req
//  tx_enable  out  1            to transmitter enable; one-cycle pulse per byte
//  tx_data    out  8            to transmitter data_in; stable from LOAD through WAIT_DONE
//  tx_done    in   1            from transmitter done; one-cycle pulse at end of stop bit
//  busy       out  1            1 in every state except IDLE
//  grant_id   out  ID_W         index of last/current granted requester
//  timeout    out  1            one-cycle pulse when the watchdog aborts a transfer
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge)
//   - ack=0, tx_enable=0, tx_data=0, grant_id=0, timeout=0, busy=1.
//   - rr_ptr=0, counter=0, state=HOLDOFF. Applies mid-transfer too; any byte in
//     flight is lost and its requester is not acked again.
//  States
//   HOLDOFF   - count HOLDOFF_CYC cycles (transmitter has no reset and may still be
//               mid-frame); then IDLE. req ignored.
//   IDLE      - busy=0. If any req bit set: pick first set bit searching
//               rr_ptr, rr_ptr+1, ... (mod NUM_REQ); latch its byte into tx_data;
//               set grant_id; go LOAD. No req: stay.
//   LOAD      - exactly one cycle: tx_enable=1, ack[grant_id]=1,
//               rr_ptr <= grant_id+1 (wraps NUM_REQ-1 -> 0), counter cleared; go WAIT_DONE.
//   WAIT_DONE - tx_enable=0, counter++ each cycle.
//               tx_done=1 -> IDLE next cycle.
//               counter reaches TIMEOUT_CYC-1 without done -> timeout=1 for one cycle,
//               go HOLDOFF (counter cleared).
//  Latency
//   - req seen in IDLE at edge N: tx_enable and ack high during cycle N+1.
//   - tx_done at edge M: back in IDLE at M+1; next tx_enable at M+2 at earliest.
//     This respects the transmitter's one-cycle idle before it samples enable.
//  Rules and boundaries
//   - tx_done outside WAIT_DONE ignored. tx_done and timeout on the same cycle: done wins.
//   - Requester dropping req before ack: not an error; if not yet chosen, simply skipped.
//   - At most one ack bit high at any time; ack never high outside LOAD.
//   - All requesters asserting continuously: grants rotate 0,1,..,NUM_REQ-1,0 (fairness).
//   - Single requester held high: granted every round, one byte per frame.
//   - data_in sampled only in the IDLE->LOAD edge; later changes do not affect tx_data.
// TESTING
//  1 Reset: rst_n low 3 cycles, req=4'b1111 -> no tx_enable/ack for HOLDOFF_CYC cycles,
//    busy=1; then first grant to id 0 (data 0xA0 -> tx_data=0xA0).
//  2 Fairness: req=4'b1111, bytes 0xA0..0xA3, model done after each frame ->
//    tx order A0,A1,A2,A3,A0; ack order 0,1,2,3,0; one tx_enable per byte.
//  3 Wrap/skip: rr_ptr=3, req=4'b0101 -> grant 0, then 2; req[3] rising mid-frame
//    -> served after 2, before 0 again.
//  4 Handshake timing: req[1]=1 in IDLE at edge N -> ack[1], tx_enable at N+1 only.
//    tx_done at M -> busy=0 at M+1. With real UART_TX (clk_per_bit=4), serial line
//    decodes 0x5A.
//  5 Watchdog: tx_done never pulses -> timeout pulse after TIMEOUT_CYC cycles, then
//    HOLDOFF; no re-ack of the aborted requester.
//  6 Reset mid-WAIT_DONE and tx_done at the same cycle as timeout -> reset/done win
//    respectively; state HOLDOFF / IDLE as specified, no spurious ack.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer that shares one 8-bit UART transmitter between NUM_REQ byte
// sources, with a post-reset holdoff and a watchdog on the transmitter's done pulse.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int HOLDOFF_CYC = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_enable,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    S_HOLDOFF,
    S_IDLE,
    S_LOAD,
    S_WAIT_DONE
  } state_t;

  localparam int MAX_CYC = (HOLDOFF_CYC > TIMEOUT_CYC) ? HOLDOFF_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   rr_ptr;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   idx;

  // Scan from the highest offset down so the last hit is the first one after rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    tx_enable = 1'b0;
    ack       = '0;
    timeout   = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_HOLDOFF: begin
        if (cnt == CNT_W'(HOLDOFF_CYC - 1)) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (pick_valid) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        tx_enable     = 1'b1;
        ack[grant_id] = 1'b1;
        state_nxt     = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A done arriving on the watchdog's last cycle still completes the byte.
        if (tx_done) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout   = 1'b1;
          state_nxt = S_HOLDOFF;
        end
      end
      default: state_nxt = S_HOLDOFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_HOLDOFF;
      cnt      <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
      tx_data  <= '0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state == S_HOLDOFF || state == S_WAIT_DONE) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state == S_IDLE && pick_valid) begin
        grant_id <= pick_id;
        tx_data  <= data_in[8*int'(pick_id) +: 8];
      end

      if (state == S_LOAD) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester and transmitter models, with a
// scoreboard monitor that checks every granted byte against a queue of expectations.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int HOLDOFF_CYC = 64;
  localparam int TIMEOUT_CYC = 1024;
  localparam int FRAME_CYC   = 40;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_enable;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;
  logic                 timeout;

  int   checks   = 0;
  int   failures = 0;
  int   target[NUM_REQ] = '{default: 0};
  int   acked[NUM_REQ]  = '{default: 0};
  exp_t sb[$];
  exp_t mon_e;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ID_W       (ID_W),
    .HOLDOFF_CYC(HOLDOFF_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .tx_enable(tx_enable),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .grant_id (grant_id),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Each requester holds req while it still has bytes owed (target > acked).
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_REQ; i++) req[i] = (acked[i] < target[i]);
  end

  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) if (ack[i]) acked[i]++;
  end

  // Scoreboard monitor: every enable/ack cycle must match the next expected grant.
  always @(negedge clk) begin
    if (tx_enable || ack != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", {27'd0, tx_enable, ack}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("grant_id", grant_id, mon_e.id);
        check("tx_data", tx_data, mon_e.data);
        check("ack_onehot", ack, 4'b0001 << mon_e.id);
        check("tx_enable_with_ack", tx_enable, 1);
      end
    end
  end

  task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_enable(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_enable && n < 3000);
    check(name, tx_enable, 1);
  endtask

  // Transmitter model: done pulse some cycles after enable; idle right after.
  task automatic finish_frame(input int delay);
    repeat (delay) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int quiet;
    int n;
    int en_seen;

    // Reset and holdoff, all requesters pending.
    rst_n   = 1'b0;
    tx_done = 1'b0;
    data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    target  = '{2, 1, 1, 1};
    push_exp(2'd0, 8'hA0);
    push_exp(2'd1, 8'hA1);
    push_exp(2'd2, 8'hA2);
    push_exp(2'd3, 8'hA3);
    push_exp(2'd0, 8'hA0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1);
    check("reset_tx_enable", tx_enable, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_timeout", timeout, 0);
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < HOLDOFF_CYC; i++) begin
      @(negedge clk);
      if (tx_enable || ack != '0) quiet++;
      if (i < HOLDOFF_CYC - 1 && !busy) quiet++;
    end
    check("holdoff_quiet", quiet, 0);
    check("idle_after_holdoff", busy, 0);
    @(negedge clk);
    check("first_enable", tx_enable, 1);
    finish_frame(FRAME_CYC);

    // Fairness: rotation 1,2,3 then back to 0.
    for (int i = 0; i < 4; i++) begin
      wait_enable("fair_enable");
      finish_frame(FRAME_CYC);
    end

    // Wrap/skip from rr_ptr=3, late requester, data sampled only at grant.
    data_in = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    push_exp(2'd2, 8'hB2);
    target[2]++;
    wait_enable("setup_enable");
    finish_frame(FRAME_CYC);
    push_exp(2'd0, 8'hB0);
    push_exp(2'd2, 8'hB2);
    push_exp(2'd3, 8'hB3);
    push_exp(2'd0, 8'hC0);
    target[0]++;
    target[2]++;
    wait_enable("wrap_enable0");
    data_in[7:0] = 8'hC0;
    target[0]++;
    repeat (3) @(negedge clk);
    check("tx_data_hold", tx_data, 8'hB0);
    finish_frame(FRAME_CYC - 3);
    wait_enable("wrap_enable2");
    target[3]++;
    finish_frame(FRAME_CYC);
    wait_enable("wrap_enable3");
    finish_frame(FRAME_CYC);
    wait_enable("wrap_enable0b");
    finish_frame(FRAME_CYC);

    // Handshake timing for a single request.
    data_in[15:8] = 8'h5A;
    push_exp(2'd1, 8'h5A);
    target[1]++;
    @(negedge clk);
    check("load_timing_enable", tx_enable, 1);
    check("load_timing_ack", ack, 4'b0010);
    @(negedge clk);
    check("enable_pulse_width", tx_enable, 0);
    check("ack_pulse_width", ack, 0);
    check("busy_wait_done", busy, 1);
    finish_frame(3);

    // Stray done while idle must be ignored.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("stray_done_idle_busy", busy, 0);
    check("stray_done_idle_enable", tx_enable, 0);

    // Watchdog abort with no done.
    data_in[23:16] = 8'h77;
    push_exp(2'd2, 8'h77);
    target[2]++;
    wait_enable("wd_enable");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout && n < 2000);
    check("timeout_latency", n, TIMEOUT_CYC);
    @(negedge clk);
    check("timeout_pulse_width", timeout, 0);
    check("holdoff_after_timeout", busy, 1);
    en_seen = 0;
    repeat (HOLDOFF_CYC + 4) begin
      @(negedge clk);
      if (tx_enable) en_seen++;
    end
    check("no_reack_after_timeout", en_seen, 0);
    check("idle_after_wd_holdoff", busy, 0);

    // Reset in the middle of WAIT_DONE.
    data_in[31:24] = 8'h33;
    push_exp(2'd3, 8'h33);
    target[3]++;
    wait_enable("mid_reset_enable");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 1);
    check("midreset_tx_data", tx_data, 0);
    check("midreset_grant_id", grant_id, 0);
    check("midreset_ack", ack, 0);
    rst_n   = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("stray_done_holdoff", busy, 1);
    en_seen = 0;
    repeat (HOLDOFF_CYC + 4) begin
      @(negedge clk);
      if (tx_enable) en_seen++;
    end
    check("no_spurious_after_reset", en_seen, 0);
    check("idle_after_reset_holdoff", busy, 0);

    // Done arriving on the watchdog's final cycle wins.
    data_in[7:0] = 8'h11;
    push_exp(2'd0, 8'h11);
    target[0]++;
    wait_enable("late_done_enable");
    repeat (TIMEOUT_CYC) @(negedge clk);
    tx_done = 1'b1;
    #1;
    check("done_beats_timeout", timeout, 0);
    @(negedge clk);
    tx_done = 1'b0;
    check("idle_after_late_done", busy, 0);
    check("no_timeout_after_done", timeout, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
